// File: rtl/hazard_ctrl.sv
// hazard_ctrl: load-use / branch-flush / memory-freeze sequencing and ALU operand
// forwarding for the 5-stage MIPS pipeline. Define HAZARD_FWD_EN to enable forwarding.
module hazard_ctrl #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [4:0]       idRs,
  input  logic [4:0]       idRt,
  input  logic             idUsesRt,
  input  logic [4:0]       exRd,
  input  logic             exWe,
  input  logic             exIsLoad,
  input  logic [4:0]       meRd,
  input  logic             meWe,
  input  logic             meTaken,
  input  logic [4:0]       wbRd,
  input  logic             wbWe,
  input  logic             memBusy,
  output logic             pcEn,
  output logic             ifidEn,
  output logic             idexEn,
  output logic             exmeEn,
  output logic             mewbEn,
  output logic             ifidBubble,
  output logic             idexBubble,
  output logic             exmeBubble,
  output logic             mewbBubble,
  output logic             pcRedirect,
  output logic [1:0]       fwdA,
  output logic [1:0]       fwdB,
  output logic [CNT_W-1:0] stallCnt
);

  typedef enum logic [1:0] {
    RUN     = 2'd0,
    LDSTALL = 2'd1,
    FREEZE  = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic             ex_valid, me_valid;
  logic             rs_ex_hit, rt_ex_hit;
  logic             raw_match, load_use;

  always_comb begin
    ex_valid  = exWe && (exRd != 5'd0);
    me_valid  = meWe && (meRd != 5'd0);
    rs_ex_hit = ex_valid && (exRd == idRs);
    rt_ex_hit = ex_valid && idUsesRt && (exRd == idRt);
  end

`ifdef HAZARD_FWD_EN
  logic wb_valid;

  // ALU results reach the reader through the bypass muxes; only a load is too late.
  always_comb begin
    wb_valid  = wbWe && (wbRd != 5'd0);
    raw_match = exIsLoad && (rs_ex_hit || rt_ex_hit);
  end

  always_comb begin
    fwdA = 2'd0;
    fwdB = 2'd0;
    if (rst_n) begin
      if (me_valid && (meRd == idRs))      fwdA = 2'd1;
      else if (wb_valid && (wbRd == idRs)) fwdA = 2'd2;
      if (me_valid && (meRd == idRt))      fwdB = 2'd1;
      else if (wb_valid && (wbRd == idRt)) fwdB = 2'd2;
    end
  end
`else
  logic rs_me_hit, rt_me_hit;
  logic unused_no_fwd;

  // No bypass: a producer still in EX or ME blocks the reader. WB writes before ID reads.
  always_comb begin
    rs_me_hit = me_valid && (meRd == idRs);
    rt_me_hit = me_valid && idUsesRt && (meRd == idRt);
    raw_match = rs_ex_hit || rt_ex_hit || rs_me_hit || rt_me_hit;
    fwdA      = 2'd0;
    fwdB      = 2'd0;
  end

  assign unused_no_fwd = ^{exIsLoad, wbRd, wbWe};
`endif

  always_comb begin
    load_use = raw_match;
    if (state_q == LDSTALL) begin
`ifdef HAZARD_FWD_EN
      // ID/EX holds the bubble we just inserted, so the stall never repeats.
      load_use = 1'b0;
`endif
    end
  end

  always_comb begin
    pcEn       = 1'b1;
    ifidEn     = 1'b1;
    idexEn     = 1'b1;
    exmeEn     = 1'b1;
    mewbEn     = 1'b1;
    ifidBubble = 1'b0;
    idexBubble = 1'b0;
    exmeBubble = 1'b0;
    mewbBubble = 1'b0;
    pcRedirect = 1'b0;
    if (!rst_n) begin
      pcEn       = 1'b0;
      ifidBubble = 1'b1;
      idexBubble = 1'b1;
      exmeBubble = 1'b1;
      mewbBubble = 1'b1;
    end else if (memBusy) begin
      pcEn   = 1'b0;
      ifidEn = 1'b0;
      idexEn = 1'b0;
      exmeEn = 1'b0;
      mewbEn = 1'b0;
    end else if (meTaken) begin
      pcRedirect = 1'b1;
      ifidBubble = 1'b1;
      idexBubble = 1'b1;
      exmeBubble = 1'b1;
    end else if (load_use) begin
      pcEn       = 1'b0;
      ifidEn     = 1'b0;
      idexBubble = 1'b1;
    end
  end

  always_comb begin
    state_d = RUN;
    if (memBusy)       state_d = FREEZE;
    else if (meTaken)  state_d = RUN;
    else if (load_use) state_d = LDSTALL;

    stall_cnt_d = stall_cnt_q;
    if (!pcEn && (stall_cnt_q != {CNT_W{1'b1}}))
      stall_cnt_d = stall_cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= RUN;
      stall_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign stallCnt = stall_cnt_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// tb_hazard_ctrl: directed test-plan steps followed by random cycles, every cycle
// checked against a rule-level reference model of the hazard controller.
module tb_hazard_ctrl;

  localparam int CNT_W   = 4;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             rst_n;
  logic [4:0]       idRs, idRt, exRd, meRd, wbRd;
  logic             idUsesRt, exWe, exIsLoad, meWe, meTaken, wbWe, memBusy;
  logic             pcEn, ifidEn, idexEn, exmeEn, mewbEn;
  logic             ifidBubble, idexBubble, exmeBubble, mewbBubble, pcRedirect;
  logic [1:0]       fwdA, fwdB;
  logic [CNT_W-1:0] stallCnt;

  int    vectors = 0;
  int    miscompares = 0;
  bit    mLdPrev;
  int    mCnt;
  string stepTag;

  hazard_ctrl #(.CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .idRs(idRs), .idRt(idRt), .idUsesRt(idUsesRt),
    .exRd(exRd), .exWe(exWe), .exIsLoad(exIsLoad),
    .meRd(meRd), .meWe(meWe), .meTaken(meTaken),
    .wbRd(wbRd), .wbWe(wbWe), .memBusy(memBusy),
    .pcEn(pcEn), .ifidEn(ifidEn), .idexEn(idexEn), .exmeEn(exmeEn), .mewbEn(mewbEn),
    .ifidBubble(ifidBubble), .idexBubble(idexBubble), .exmeBubble(exmeBubble),
    .mewbBubble(mewbBubble), .pcRedirect(pcRedirect),
    .fwdA(fwdA), .fwdB(fwdB), .stallCnt(stallCnt)
  );

  task automatic applyStimulus(input logic r, input logic [4:0] rs, input logic [4:0] rt,
                               input logic usesRt, input logic [4:0] xrd, input logic xwe,
                               input logic xld, input logic [4:0] mrd, input logic mwe,
                               input logic taken, input logic [4:0] wrd, input logic wwe,
                               input logic busy);
    rst_n = r; idRs = rs; idRt = rt; idUsesRt = usesRt;
    exRd = xrd; exWe = xwe; exIsLoad = xld;
    meRd = mrd; meWe = mwe; meTaken = taken;
    wbRd = wrd; wbWe = wwe; memBusy = busy;
    #1;
  endtask

  task automatic checkConst(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference model: evaluate the priority rules on the current inputs, compare, then
  // advance the model's memory (previous-cycle load stall, saturating stall count).
  task automatic checkOutput();
    bit exV, meV, wbV, rsEx, rtEx, rsMe, rtMe, hazard;
    bit pc, en1, en2, en3, en4, b1, b2, b3, b4, redir;
    int fa, fb;
    logic [9:0] expCtrl, obsCtrl;
    exV  = exWe && exRd != 0;
    meV  = meWe && meRd != 0;
    wbV  = wbWe && wbRd != 0;
    rsEx = exV && exRd == idRs;
    rtEx = exV && idUsesRt && exRd == idRt;
    rsMe = meV && meRd == idRs;
    rtMe = meV && idUsesRt && meRd == idRt;
`ifdef HAZARD_FWD_EN
    hazard = exIsLoad && (rsEx || rtEx) && !mLdPrev;
`else
    hazard = rsEx || rtEx || rsMe || rtMe;
`endif
    {pc, en1, en2, en3, en4, b1, b2, b3, b4, redir} = {1'b1, 4'b1111, 4'b0000, 1'b0};
    if (!rst_n)        {pc, b1, b2, b3, b4} = {1'b0, 4'b1111};
    else if (memBusy)  {pc, en1, en2, en3, en4} = 5'b0;
    else if (meTaken)  {redir, b1, b2, b3} = 4'b1111;
    else if (hazard)   {pc, en1, b2} = 3'b001;
    fa = 0;
    fb = 0;
`ifdef HAZARD_FWD_EN
    if (rst_n) begin
      fa = (meV && meRd == idRs) ? 1 : (wbV && wbRd == idRs) ? 2 : 0;
      fb = (meV && meRd == idRt) ? 1 : (wbV && wbRd == idRt) ? 2 : 0;
    end
`endif
    expCtrl = {pc, en1, en2, en3, en4, b1, b2, b3, b4, redir};
    obsCtrl = {pcEn, ifidEn, idexEn, exmeEn, mewbEn,
               ifidBubble, idexBubble, exmeBubble, mewbBubble, pcRedirect};
    vectors++;
    assert (obsCtrl === expCtrl) else begin
      miscompares++;
      $error("[TB] FAIL %s ctrl observed=%b expected=%b", stepTag, obsCtrl, expCtrl);
    end
    vectors++;
    assert ({fwdA, fwdB} === {2'(fa), 2'(fb)}) else begin
      miscompares++;
      $error("[TB] FAIL %s fwd observed=%0d/%0d expected=%0d/%0d", stepTag, fwdA, fwdB, fa, fb);
    end
    vectors++;
    assert (stallCnt === CNT_W'(mCnt)) else begin
      miscompares++;
      $error("[TB] FAIL %s stallCnt observed=%0d expected=%0d", stepTag, stallCnt, mCnt);
    end
    mLdPrev = rst_n && !memBusy && !meTaken && hazard;
    if (!rst_n)  mCnt = 0;
    else if (!pc) mCnt = (mCnt + 1 > CNT_MAX) ? CNT_MAX : mCnt + 1;
    @(negedge clk);
  endtask

  initial begin
    applyStimulus(0, 0,0,0, 0,0,0, 0,0,0, 0,0,0);
    @(posedge clk);
    @(negedge clk);
    mLdPrev = 0;
    mCnt    = 0;

    stepTag = "reset";
    applyStimulus(0, 0,0,0, 0,0,0, 0,0,0, 0,0,0);
    checkConst("reset_bubbles", {ifidBubble, idexBubble, exmeBubble, mewbBubble}, 4'hF);
    checkConst("reset_pcEn", pcEn, 0);
    checkOutput();

    stepTag = "loaduse";
    applyStimulus(1, 5,0,0, 5,1,1, 0,0,0, 0,0,0);
    checkConst("lu_pc_ifid", {pcEn, ifidEn}, 2'b00);
    checkConst("lu_idexBubble", idexBubble, 1);
    checkOutput();
    stepTag = "loaduse_me";
    applyStimulus(1, 5,0,0, 0,0,0, 5,1,0, 0,0,0);
    checkConst("lu_cnt", stallCnt, 1);
`ifdef HAZARD_FWD_EN
    checkConst("lu_run", pcEn, 1);
`else
    checkConst("lu_restall", pcEn, 0);
`endif
    checkOutput();
    stepTag = "loaduse_wb";
    applyStimulus(1, 5,0,0, 0,0,0, 0,0,0, 5,1,0);
    checkConst("lu_wb_pcEn", pcEn, 1);
`ifdef HAZARD_FWD_EN
    checkConst("lu_fwdA_wb", fwdA, 2);
`endif
    checkOutput();

    stepTag = "flush_over_loaduse";
    applyStimulus(1, 5,0,0, 5,1,1, 0,0,1, 0,0,0);
    checkConst("flush_redirect_pc", {pcRedirect, pcEn}, 2'b11);
    checkConst("flush_bubbles", {ifidBubble, idexBubble, exmeBubble, mewbBubble}, 4'b1110);
    checkOutput();

    stepTag = "freeze_reset";
    applyStimulus(0, 0,0,0, 0,0,0, 0,0,0, 0,0,0);
    checkOutput();
    stepTag = "freeze_taken";
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1, 0,0,0, 0,0,0, 3,1,1, 0,0,1);
      checkConst("freeze_en", {pcEn, ifidEn, idexEn, exmeEn, mewbEn}, 5'b0);
      checkOutput();
    end
    stepTag = "deferred_flush";
    applyStimulus(1, 0,0,0, 0,0,0, 3,1,1, 0,0,0);
    checkConst("deferred_redirect", pcRedirect, 1);
    checkConst("freeze_cnt", stallCnt, 4);
    checkOutput();

    stepTag = "fwd_priority";
    applyStimulus(1, 7,0,0, 0,0,0, 7,1,0, 7,1,0);
`ifdef HAZARD_FWD_EN
    checkConst("fwdA_me", fwdA, 1);
`else
    checkConst("fwdA_off", fwdA, 0);
`endif
    checkOutput();
    stepTag = "fwd_r0";
    applyStimulus(1, 0,0,0, 0,0,0, 0,1,0, 0,1,0);
    checkConst("fwdA_r0", fwdA, 0);
    checkOutput();

    stepTag = "reset_in_freeze";
    applyStimulus(1, 0,0,0, 0,0,0, 0,0,0, 0,0,1);
    checkOutput();
    applyStimulus(0, 0,0,0, 0,0,0, 0,0,0, 0,0,1);
    checkConst("rif_bubbles", {ifidBubble, idexBubble, exmeBubble, mewbBubble}, 4'hF);
    checkConst("rif_en", {pcEn, ifidEn, idexEn, exmeEn, mewbEn}, 5'b01111);
    checkOutput();
    stepTag = "after_reset";
    applyStimulus(1, 0,0,0, 0,0,0, 0,0,0, 0,0,0);
    checkConst("ar_cnt", stallCnt, 0);
    checkConst("ar_pcEn", pcEn, 1);
    checkOutput();

    stepTag = "alu_raw";
    applyStimulus(1, 0,3,1, 3,1,0, 0,0,0, 0,0,0);
`ifdef HAZARD_FWD_EN
    checkConst("alu_nostall", pcEn, 1);
`else
    checkConst("alu_stall1", pcEn, 0);
`endif
    checkOutput();
    applyStimulus(1, 0,3,1, 0,0,0, 3,1,0, 0,0,0);
`ifndef HAZARD_FWD_EN
    checkConst("alu_stall2", pcEn, 0);
`endif
    checkOutput();
    applyStimulus(1, 0,3,1, 0,0,0, 0,0,0, 3,1,0);
    checkConst("alu_run", pcEn, 1);
    checkOutput();

    stepTag = "saturate";
    for (int i = 0; i < CNT_MAX + 3; i++) begin
      applyStimulus(1, 0,0,0, 0,0,0, 0,0,0, 0,0,1);
      checkOutput();
    end
    applyStimulus(1, 0,0,0, 0,0,0, 0,0,0, 0,0,0);
    checkConst("sat_cnt", stallCnt, 16'(CNT_MAX));
    checkOutput();

    stepTag = "random";
    for (int i = 0; i < 1500; i++) begin
      applyStimulus(($urandom_range(0, 49) != 0),
                    5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 1'($urandom),
                    5'($urandom_range(0, 3)), 1'($urandom), 1'($urandom),
                    5'($urandom_range(0, 3)), 1'($urandom), ($urandom_range(0, 5) == 0),
                    5'($urandom_range(0, 3)), 1'($urandom), ($urandom_range(0, 4) == 0));
      checkOutput();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/hazard_ctrl.md
# hazard_ctrl

Pipeline hazard and sequencing controller for the 5-stage MIPS datapath. It drives the `en` and `bubbleSel` inputs of the IF/ID, ID/EX, EX/ME and ME/WB pipeline registers and the PC load enable. It detects load-use hazards, squashes wrong-path instructions on a taken branch, freezes the pipeline while data memory is busy, and selects ALU operand forwarding. A saturating stall-cycle counter supports performance debug.

## Interface
Parameters:
- `CNT_W`, default 16, width of the stall-cycle counter.

Ports:
- `clk`  in  1  pipeline clock; all state updates on the rising edge.
- `rst_n`  in  1  reset, synchronous, active-low.
- `idRs`, `idRt`  in  5 each  source registers of the instruction in IF/ID.
- `idUsesRt`  in  1  the ID instruction reads `idRt`.
- `exRd`  in  5  ID/EX destination register.
- `exWe`  in  1  ID/EX instruction writes a register.
- `exIsLoad`  in  1  ID/EX instruction is `lw`.
- `meRd`  in  5  EX/ME destination register.
- `meWe`  in  1  EX/ME instruction writes a register.
- `meTaken`  in  1  EX/ME holds a branch with `zeroOut`=1.
- `wbRd`  in  5  ME/WB destination register.
- `wbWe`  in  1  ME/WB instruction writes a register.
- `memBusy`  in  1  data memory is not ready this cycle.
- `pcEn`  out  1  PC register load enable.
- `ifidEn`, `idexEn`, `exmeEn`, `mewbEn`  out  1 each  pipeline register enables.
- `ifidBubble`, `idexBubble`, `exmeBubble`, `mewbBubble`  out  1 each  load a nop (all-zero) on the next edge.
- `pcRedirect`  out  1  PC mux selects the branch target.
- `fwdA`, `fwdB`  out  2 each  operand select: 0 = register file, 1 = EX/ME ALU result, 2 = ME/WB writeback value.
- `stallCnt`  out  `CNT_W`  saturating count of cycles with `pcEn`=0.

## Operation
- A hazard source is valid only if its write enable is 1 and its `Rd` is not 0. Register 0 never creates a hazard and is never forwarded.
- The FSM has three states: RUN, LDSTALL and FREEZE. The next state is evaluated in priority order. The same priority order also sets the outputs for the current cycle.
  1. `memBusy`=1 → FREEZE. All `en` signals and `pcEn` are 0, all bubbles are 0, and `pcRedirect` is 0. FREEZE holds while `memBusy`=1 and returns to RUN when it drops.
  2. `meTaken`=1 (branch flush) → RUN. `pcRedirect`=1, `pcEn`=1 and all `en`=1. `ifidBubble`, `idexBubble` and `exmeBubble` are 1. Any load-use condition in the same cycle is ignored, because the instruction that caused it is squashed.
  3. Load-use → LDSTALL. Load-use is `exIsLoad` & valid `exRd`, with `exRd`==`idRs`, or with `idUsesRt` & `exRd`==`idRt`. Outputs: `pcEn`=0, `ifidEn`=0, `idexBubble`=1, and the other `en`=1.
  4. Otherwise → RUN. All `en`=1 and all bubbles are 0.
- LDSTALL lasts exactly one cycle. In that cycle the outputs are evaluated normally under rules 1, 2 and 4. Rule 3 cannot fire, because ID/EX now holds a bubble.
- Forwarding (per operand, `idRs`→`fwdA`, `idRt`→`fwdB`): a match on a valid `meRd` gives 1. Otherwise a match on a valid `wbRd` gives 2. Otherwise the select is 0. EX/ME takes priority when both match.
- `stallCnt` increments on every clock edge where `pcEn`=0 and stops at all-ones.

## Timing
- Enable, bubble and forward outputs are combinational from the state and the inputs. The state and `stallCnt` are registered.
- Reset: when `rst_n`=0 at a rising edge, the state becomes RUN and `stallCnt` becomes 0. While `rst_n`=0, the outputs are: all `en`=1, all bubbles=1, `pcEn`=0, `pcRedirect`=0, `fwdA`=`fwdB`=0. This flushes every stage to a nop.
- Reset takes effect in the middle of FREEZE or LDSTALL. The next state is RUN regardless of `memBusy`.
- A load-use stall costs 1 cycle. A taken branch costs 3 squashed slots. A FREEZE costs N cycles for N busy cycles.
- If `memBusy` and `meTaken` are both 1, the flush is deferred. It is applied on the first cycle after `memBusy` drops, because EX/ME still holds the branch.

## Configuration
- `HAZARD_FWD_EN` defined: forwarding is active as described above.
- `HAZARD_FWD_EN` undefined: `fwdA`=`fwdB`=0 always. Rule 3 widens to any RAW match of `idRs`/`idRt` against a valid `exRd` or `meRd`, regardless of `exIsLoad`. The stall repeats each cycle until no match remains, with the FSM staying in LDSTALL. A match against `wbRd` does not stall, because the register file writes before it reads.

## Test plan
- `lw` with `exRd`=5, `idRs`=5 → one cycle of `pcEn`=0, `ifidEn`=0, `idexBubble`=1. The next cycle is RUN, `fwdA`=2 once the load reaches WB, and `stallCnt`=1.
- `meTaken`=1 together with a load-use match → `pcRedirect`=1, three bubbles, and no stall.
- `memBusy` high for 4 cycles with `meTaken`=1 → all `en`=0 for 4 cycles, then the flush, and `stallCnt`=4.
- `meRd`=`wbRd`=7, `idRs`=7, both write enables=1 → `fwdA`=1. With `meRd`=0, `idRs`=0 → `fwdA`=0.
- `rst_n`=0 during FREEZE → all bubbles=1, and after release the state is RUN and `stallCnt`=0.
- With `HAZARD_FWD_EN` undefined and an ALU write `exRd`=3 with `idRt`=3 and `idUsesRt`=1 → 2 stall cycles, then RUN.
